// File: rtl/pkt_buff_out_arbiter.sv
// Round-robin arbiter muxing NUM_BUFS packet buffers onto one registered output port.
// Optional grant watchdog enabled by defining ARB_WATCHDOG_EN.
module pkt_buff_out_arbiter #(
    parameter int NUM_BUFS    = 4,
    parameter int IDX_W       = 2,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_BUFS-1:0]      buf_req,
    output logic [NUM_BUFS-1:0]      buf_ack,
    output logic [NUM_BUFS-1:0]      buf_rdy,
    input  logic [64*NUM_BUFS-1:0]   buf_data,
    input  logic [24*NUM_BUFS-1:0]   buf_pkt_route,
    input  logic [NUM_BUFS-1:0]      buf_wr,
    input  logic [NUM_BUFS-1:0]      buf_bop,
    input  logic [NUM_BUFS-1:0]      buf_eop,
    output logic [63:0]              out_data,
    output logic [23:0]              out_pkt_route,
    output logic                     out_wr,
    output logic                     out_bop,
    output logic                     out_eop,
    input  logic                     out_rdy,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     proto_err,
    output logic                     wdog_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_e;

    localparam logic [IDX_W:0] NB = (IDX_W+1)'(NUM_BUFS);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_BUFS-1:0]  eligible;
    logic [NUM_BUFS-1:0]  grant_oh;
    logic                 release_req;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W:0]       cand;
    logic [63:0]          data_arr  [NUM_BUFS];
    logic [23:0]          route_arr [NUM_BUFS];

    logic [63:0]          out_data_q;
    logic [23:0]          out_route_q;
    logic                 out_wr_q, out_bop_q, out_eop_q;
    logic                 proto_err_q;

    generate
        for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_unpack
            assign data_arr[gi]  = buf_data[64*gi +: 64];
            assign route_arr[gi] = buf_pkt_route[24*gi +: 24];
            assign grant_oh[gi]  = (grant_idx_q == IDX_W'(gi));
        end
    endgenerate

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0]      wdog_cnt_q, wdog_cnt_d;
    logic [NUM_BUFS-1:0]  mask_q, mask_d;
    logic                 wdog_err_q;
    logic                 wdog_fire;

    assign wdog_fire = (state_q == ST_GRANT) && !buf_wr[grant_idx_q] &&
                       (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1));

    // A timed-out buffer stays masked until it drops its request.
    always_comb begin
        wdog_cnt_d = '0;
        if (state_q == ST_GRANT && state_d == ST_GRANT && !buf_wr[grant_idx_q]) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        mask_d = mask_q & buf_req;
        if (wdog_fire) begin
            mask_d[grant_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_q <= '0;
            mask_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            mask_q     <= mask_d;
            wdog_err_q <= wdog_err_q | wdog_fire;
        end
    end

    assign eligible    = buf_req & ~mask_q;
    assign release_req = !buf_req[grant_idx_q] || wdog_fire;
    assign wdog_err    = wdog_err_q;
`else
    assign eligible    = buf_req;
    assign release_req = !buf_req[grant_idx_q];
    // Constant 0: the watchdog is not built in this configuration.
    assign wdog_err    = (WDOG_CYCLES < 0);
`endif

    // First eligible requester at or above the rr pointer, wrapping at NUM_BUFS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_BUFS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NB) begin
                cand = cand - NB;
            end
            if (!win_found && eligible[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d     = ST_GRANT;
                    grant_idx_d = win_idx;
                end
            end
            ST_GRANT: begin
                if (release_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_idx_q == IDX_W'(NUM_BUFS - 1)) ? '0 : grant_idx_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        buf_ack = '0;
        buf_rdy = '0;
        if (state_q == ST_GRANT) begin
            buf_ack = grant_oh;
            buf_rdy = grant_oh & {NUM_BUFS{out_rdy}};
        end
    end

    // Writes from any buffer not currently acked are dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_route_q <= '0;
            out_wr_q    <= 1'b0;
            out_bop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_q | (|(buf_wr & ~buf_ack));
            if (state_q == ST_GRANT) begin
                out_data_q <= data_arr[grant_idx_q];
                out_wr_q   <= buf_wr[grant_idx_q];
                out_bop_q  <= buf_wr[grant_idx_q] & buf_bop[grant_idx_q];
                out_eop_q  <= buf_wr[grant_idx_q] & buf_eop[grant_idx_q];
                if (buf_wr[grant_idx_q] && buf_bop[grant_idx_q]) begin
                    out_route_q <= route_arr[grant_idx_q];
                end
            end else begin
                out_wr_q  <= 1'b0;
                out_bop_q <= 1'b0;
                out_eop_q <= 1'b0;
            end
        end
    end

    assign out_data      = out_data_q;
    assign out_pkt_route = out_route_q;
    assign out_wr        = out_wr_q;
    assign out_bop       = out_bop_q;
    assign out_eop       = out_eop_q;
    assign grant_idx     = grant_idx_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_pkt_buff_out_arbiter.sv
// Bench for pkt_buff_out_arbiter: ownership-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pkt_buff_out_arbiter;

    localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] BASE1 = 64'hA5A5_0000_0000_0100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   in_req = '0, in_wr = '0, in_bop = '0, in_eop = '0;
    logic [63:0]  in_data  [4];
    logic [23:0]  in_route [4];
    logic         out_rdy = 1'b1;
    logic [255:0] bus_data;
    logic [95:0]  bus_route;

    logic [3:0]   buf_ack, buf_rdy;
    logic [63:0]  out_data;
    logic [23:0]  out_pkt_route;
    logic         out_wr, out_bop, out_eop;
    logic [1:0]   grant_idx;
    logic         proto_err, wdog_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        bus_data  = '0;
        bus_route = '0;
        for (int i = 0; i < 4; i++) begin
            bus_data[64*i +: 64]  = in_data[i];
            bus_route[24*i +: 24] = in_route[i];
        end
    end

    pkt_buff_out_arbiter #(.NUM_BUFS(4), .IDX_W(2), .WDOG_CYCLES(4096)) dut (
        .clk(clk), .reset_n(reset_n),
        .buf_req(in_req), .buf_ack(buf_ack), .buf_rdy(buf_rdy),
        .buf_data(bus_data), .buf_pkt_route(bus_route),
        .buf_wr(in_wr), .buf_bop(in_bop), .buf_eop(in_eop),
        .out_data(out_data), .out_pkt_route(out_pkt_route),
        .out_wr(out_wr), .out_bop(out_bop), .out_eop(out_eop),
        .out_rdy(out_rdy), .grant_idx(grant_idx),
        .proto_err(proto_err), .wdog_err(wdog_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns the port, the round-robin start and the post-release gap.
    int          m_owner = -1;
    int          m_rr    = 0;
    int          m_cool  = 0;
    int          mj;
    logic [1:0]  mo;
    logic        m_found;
    logic        exp_wr = 0, exp_bop = 0, exp_eop = 0, exp_proto = 0;
    logic [63:0] exp_data = '0;
    logic [23:0] exp_route = '0;
    logic [1:0]  exp_gidx = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_rr = 0; m_cool = 0;
            exp_wr = 0; exp_bop = 0; exp_eop = 0; exp_proto = 0;
            exp_data = '0; exp_route = '0; exp_gidx = '0;
        end else begin
            mo = 2'(m_owner);
            if (m_owner >= 0) begin
                exp_wr  = in_wr[mo];
                exp_bop = in_wr[mo] & in_bop[mo];
                exp_eop = in_wr[mo] & in_eop[mo];
                if (in_wr[mo]) exp_data = in_data[mo];
                if (in_wr[mo] && in_bop[mo]) exp_route = in_route[mo];
            end else begin
                exp_wr = 0; exp_bop = 0; exp_eop = 0;
            end
            for (int i = 0; i < 4; i++)
                if (in_wr[2'(i)] && i != m_owner) exp_proto = 1'b1;
            if (m_owner >= 0) begin
                if (!in_req[mo]) begin
                    m_rr    = (m_owner + 1) % 4;
                    m_owner = -1;
                    m_cool  = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                m_found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    mj = (m_rr + k) % 4;
                    if (!m_found && in_req[2'(mj)]) begin
                        m_found  = 1'b1;
                        m_owner  = mj;
                        exp_gidx = 2'(mj);
                    end
                end
            end
        end
    end

    logic [3:0] e_ack;
    always @(negedge clk) begin
        if (started && reset_n) begin
            e_ack = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            chk("ack",       64'(buf_ack),   64'(e_ack));
            chk("rdy",       64'(buf_rdy),   64'(e_ack & {4{out_rdy}}));
            chk("out_wr",    64'(out_wr),    64'(exp_wr));
            chk("out_bop",   64'(out_bop),   64'(exp_bop));
            chk("out_eop",   64'(out_eop),   64'(exp_eop));
            chk("route",     64'(out_pkt_route), 64'(exp_route));
            chk("grant_idx", 64'(grant_idx), 64'(exp_gidx));
            chk("proto_err", 64'(proto_err), 64'(exp_proto));
            chk("wdog_err",  64'(wdog_err),  64'(0));
            if (exp_wr) chk("out_data", out_data, exp_data);
        end
    end

    // Observation counters for the directed scenarios.
    int wr_cnt, bop_cnt, eop_cnt, n_rise, n_gap, last_fall;
    logic have_fall, junk_seen;
    logic [3:0] prev_ack;
    logic [63:0] first_data;
    int rise_idx [8];
    int gaps [8];

    always @(negedge clk) begin
        if (started && reset_n) begin
            if (out_wr) wr_cnt++;
            if (out_wr && out_bop) begin bop_cnt++; first_data = out_data; end
            if (out_wr && out_eop) eop_cnt++;
            if (out_wr && out_data == JUNK) junk_seen = 1'b1;
            if (buf_ack != 0 && prev_ack == 0) begin
                if (n_rise < 8) begin rise_idx[n_rise] = int'(grant_idx); n_rise++; end
                if (have_fall && n_gap < 8) begin gaps[n_gap] = cyc - last_fall; n_gap++; end
            end
            if (buf_ack == 0 && prev_ack != 0) begin last_fall = cyc; have_fall = 1'b1; end
            prev_ack = buf_ack;
        end
    end

    task automatic clear_mon();
        wr_cnt = 0; bop_cnt = 0; eop_cnt = 0; n_rise = 0; n_gap = 0;
        last_fall = 0; have_fall = 1'b0; junk_seen = 1'b0; prev_ack = '0; first_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_req = '0; in_wr = '0; in_bop = '0; in_eop = '0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin in_data[i] = '0; in_route[i] = '0; end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
        started = 1'b1;
        clear_mon();
    endtask

    task automatic wait_any_ack(output int b);
        int n = 0;
        b = 0;
        while (buf_ack == '0 && n < 20) begin step(); n++; end
        chk("ack_wait", 64'(buf_ack != 0), 64'(1));
        for (int i = 0; i < 4; i++) if (buf_ack[2'(i)]) b = i;
    endtask

    // Buffer behaviour: one word per cycle while acked and downstream ready;
    // the request drops together with the last word.
    task automatic send_pkt(input int b, input int n, input logic [63:0] base);
        int sent = 0;
        int budget = 200;
        logic [1:0] bi = 2'(b);
        while (sent < n && budget > 0) begin
            budget--;
            if (out_rdy && buf_ack[bi]) begin
                in_wr[bi]    = 1'b1;
                in_bop[bi]   = (sent == 0);
                in_eop[bi]   = (sent == n - 1);
                in_data[bi]  = base + 64'(sent);
                in_route[bi] = {8'hC0, 8'(b), 8'(sent)};
                if (sent == n - 1) in_req[bi] = 1'b0;
                sent++;
            end else begin
                in_wr[bi] = 1'b0; in_bop[bi] = 1'b0; in_eop[bi] = 1'b0;
            end
            step();
        end
        in_wr[bi] = 1'b0; in_bop[bi] = 1'b0; in_eop[bi] = 1'b0;
        chk("pkt_words_sent", 64'(sent), 64'(n));
        $display("pkt buf=%0d words=%0d cycle=%0d", b, sent, cyc);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int b;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        clear_mon();

        // Reset state
        do_reset();
        chk("rst_ack",   64'(buf_ack),   64'(0));
        chk("rst_wr",    64'(out_wr),    64'(0));
        chk("rst_data",  out_data,       64'(0));
        chk("rst_route", 64'(out_pkt_route), 64'(0));
        chk("rst_gidx",  64'(grant_idx), 64'(0));
        chk("rst_proto", 64'(proto_err), 64'(0));

        // 1: single 5-word packet from buffer 2, ack one cycle after request
        in_req[2] = 1'b1;
        step();
        chk("t1_ack_latency", 64'(buf_ack), 64'(4'b0100));
        chk("t1_gidx", 64'(grant_idx), 64'(2));
        send_pkt(2, 5, BASE1);
        step(); step(); step();
        chk("t1_wr_cnt",  64'(wr_cnt),  64'(5));
        chk("t1_bop_cnt", 64'(bop_cnt), 64'(1));
        chk("t1_eop_cnt", 64'(eop_cnt), 64'(1));
        chk("t1_first",   first_data,   BASE1);
        chk("t1_route",   64'(out_pkt_route), 64'(24'hC00200));

        // 2: all four requesting -> 0,1,2,3,0 with a 2-cycle gap between grants
        do_reset();
        in_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_any_ack(b);
            send_pkt(b, 2, 64'h2000 + 64'(n) * 64'h10);
            in_req[2'(b)] = 1'b1;
        end
        in_req = '0;
        step(); step(); step(); step();
        chk("t2_n_grants", 64'(n_rise), 64'(5));
        for (int i = 0; i < 5; i++) chk("t2_order", 64'(rise_idx[i]), 64'(exp_order[i]));
        for (int i = 0; i < 4; i++) chk("t2_gap", 64'(gaps[i]), 64'(2));

        // 3: downstream stalls for 10 cycles while buffer 1 holds the grant
        do_reset();
        in_req[1] = 1'b1;
        wait_any_ack(b);
        out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_rdy_stalled", 64'(buf_rdy), 64'(0));
        end
        chk("t3_no_wr", 64'(wr_cnt), 64'(0));
        out_rdy = 1'b1;
        send_pkt(1, 3, 64'h3000);
        step(); step();
        chk("t3_wr_cnt", 64'(wr_cnt), 64'(3));

        // 4: stray write from buffer 3 while buffer 0 owns the port
        do_reset();
        in_req[0] = 1'b1;
        wait_any_ack(b);
        chk("t4_owner", 64'(b), 64'(0));
        in_wr[3] = 1'b1; in_data[3] = JUNK;
        step();
        in_wr[3] = 1'b0;
        send_pkt(0, 3, 64'h4000);
        step(); step();
        chk("t4_proto", 64'(proto_err), 64'(1));
        chk("t4_junk_absent", 64'(junk_seen), 64'(0));
        chk("t4_wr_cnt", 64'(wr_cnt), 64'(3));

        // 5: reset mid-packet, then arbitration restarts from index 0
        do_reset();
        in_req[1] = 1'b1;
        wait_any_ack(b);
        send_pkt(1, 2, 64'h5000);
        in_req[2] = 1'b1;
        wait_any_ack(b);
        chk("t5_owner", 64'(b), 64'(2));
        in_wr[2] = 1'b1; in_bop[2] = 1'b1; in_data[2] = 64'h5100;
        step();
        in_bop[2] = 1'b0; in_data[2] = 64'h5101;
        step();
        reset_n = 1'b0;
        #1;
        chk("t5_ack_async", 64'(buf_ack), 64'(0));
        chk("t5_wr_async",  64'(out_wr),  64'(0));
        clear_inputs();
        step(); step();
        reset_n = 1'b1;
        clear_mon();
        in_req = 4'b1010;
        wait_any_ack(b);
        chk("t5_regrant_idx", 64'(grant_idx), 64'(1));
        chk("t5_regrant_ack", 64'(buf_ack), 64'(4'b0010));
        send_pkt(b, 1, 64'h5200);
        in_req = '0;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
